// File: rtl/fir_out_decim.sv
// fir_out_decim
//   Sits after the FIR filter. Keeps the first of every DECIM valid input
//   samples (sample-and-hold decimation), buffers the kept samples in a
//   first-word-fall-through FIFO, and presents them on an AXI-stream master.
//   tlast marks the last kept sample of every FRAME_LEN-sample frame. A kept
//   sample that finds the FIFO full is dropped, and the drop is recorded in a
//   sticky overflow flag.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            asynchronous active-high reset
//   in_valid       in_data carries a valid FIR sample this cycle
//   in_data        FIR sample, two's complement, passed through unmodified
//   m_axis_tvalid  FIFO holds at least one sample
//   m_axis_tready  downstream accepts the head sample
//   m_axis_tdata   head-of-FIFO sample (0 while empty)
//   m_axis_tlast   head sample closes a frame (0 while empty)
//   fifo_level     current occupancy, 0..FIFO_DEPTH
//   overflow       sticky: a kept sample was dropped
//   clr_ovf        synchronous clear of overflow (a same-edge drop wins)

module fir_out_decim #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [CW-1:0]   dec_cnt;
  logic [FW-1:0]   frm_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [DATA_W:0] head;

  logic keep;
  logic pop;
  logic wr_ok;
  logic drop;
  logic tlast_bit;

  always_comb begin
    keep      = in_valid && (dec_cnt == '0);
    pop       = m_axis_tvalid && m_axis_tready;
    // A full FIFO still accepts a write when the head pops on the same edge.
    wr_ok     = keep && ((fifo_level < FULL_LVL) || pop);
    drop      = keep && !wr_ok;
    tlast_bit = (frm_cnt == FRM_LAST);
  end

  // Decimation counter: advances on every valid input, kept or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (in_valid) begin
      if (dec_cnt == DEC_LAST) dec_cnt <= '0;
      else                     dec_cnt <= dec_cnt + CW'(1);
    end
  end

  // Frame counter: advances only for samples actually written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt <= '0;
    end else if (wr_ok) begin
      if (frm_cnt == FRM_LAST) frm_cnt <= '0;
      else                     frm_cnt <= frm_cnt + FW'(1);
    end
  end

  // Storage is not reset; occupancy is what makes entries visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {tlast_bit, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // Outputs follow the level register, so an async reset clears tvalid at once.
  always_comb begin
    head          = mem[rd_ptr];
    m_axis_tvalid = (fifo_level != '0);
    m_axis_tdata  = m_axis_tvalid ? head[DATA_W-1:0] : '0;
    m_axis_tlast  = m_axis_tvalid ? head[DATA_W] : 1'b0;
  end

endmodule

// File: tb/tb_fir_out_decim.sv
module tb_fir_out_decim;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        tready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        tvalid;
  logic [15:0] tdata;
  logic        tlast;
  logic [4:0]  level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [16:0] popped[$];
  logic [16:0] expq[$];

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [4:0]  el;
  } vec_t;

  vec_t vt[12];

  fir_out_decim #(
    .DATA_W(16),
    .DECIM(5),
    .FIFO_DEPTH(16),
    .FRAME_LEN(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata(tdata),
    .m_axis_tlast(tlast),
    .fifo_level(level),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Record the handshake seen before the edge, then advance one cycle.
  task automatic tick();
    if (tvalid && tready) popped.push_back({tlast, tdata});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    in_valid = v;
    in_data  = 16'(d);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; tready = 1'b0; clr_ovf = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    popped.delete();
    expq.delete();
  endtask

  task automatic check_stream(input string name);
    int n;
    check($sformatf("%s_count", name), 32'(popped.size()), 32'(expq.size()));
    n = (popped.size() < expq.size()) ? popped.size() : expq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", name, i), 32'(popped[i]), 32'(expq[i]));
  endtask

  initial begin
    //          v     d       rdy   ev    ed      el
    vt[0]  = '{1'b1, 16'd0,  1'b1, 1'b1, 16'd0,  5'd1};
    vt[1]  = '{1'b1, 16'd1,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[2]  = '{1'b1, 16'd2,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[3]  = '{1'b1, 16'd3,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[4]  = '{1'b1, 16'd4,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[5]  = '{1'b1, 16'd5,  1'b1, 1'b1, 16'd5,  5'd1};
    vt[6]  = '{1'b1, 16'd6,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[7]  = '{1'b0, 16'd99, 1'b1, 1'b0, 16'd0,  5'd0};
    vt[8]  = '{1'b1, 16'd7,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[9]  = '{1'b1, 16'd8,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[10] = '{1'b1, 16'd9,  1'b1, 1'b0, 16'd0,  5'd0};
    vt[11] = '{1'b1, 16'd10, 1'b1, 1'b1, 16'd10, 5'd1};

    // Ramp pass-through, one-cycle latency, gap does not advance counter.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = vt[i].v;
      in_data  = vt[i].d;
      tready   = vt[i].rdy;
      tick();
      check($sformatf("ramp_tvalid[%0d]", i), 32'(tvalid), 32'(vt[i].ev));
      check($sformatf("ramp_tdata[%0d]", i), 32'(tdata), 32'(vt[i].ed));
      check($sformatf("ramp_level[%0d]", i), 32'(level), 32'(vt[i].el));
      check($sformatf("ramp_tlast[%0d]", i), 32'(tlast), 0);
    end
    check("ramp_ovf", 32'(overflow), 0);

    // Framing with alternating input gaps: 128 outputs, tlast on 315 and 635.
    do_reset();
    tready = 1'b1;
    for (int c = 0; c < 1280; c++) drive(c[0] == 1'b0, c / 2);
    for (int c = 0; c < 10; c++) drive(1'b0, 0);
    for (int j = 0; j < 128; j++) expq.push_back({(j == 63 || j == 127) ? 1'b1 : 1'b0, 16'(5 * j)});
    check_stream("frame");
    check("frame_ovf", 32'(overflow), 0);

    // Backpressure: fill with 0..75, 80 dropped, frame count skips the drop.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, i);
      if (i == 79) check("bp_ovf_before_80", 32'(overflow), 0);
      if (i == 80) begin
        check("bp_ovf_at_80", 32'(overflow), 1);
        check("bp_level_at_80", 32'(level), 16);
        check("bp_head_stable", 32'(tdata), 0);
      end
    end
    check("bp_level_full", 32'(level), 16);
    tready = 1'b1;
    for (int i = 100; i < 340; i++) drive(1'b1, i);
    for (int c = 0; c < 30; c++) drive(1'b0, 0);
    for (int j = 0; j < 16; j++) expq.push_back({1'b0, 16'(5 * j)});
    for (int j = 0; j < 48; j++) expq.push_back({(j == 47) ? 1'b1 : 1'b0, 16'(100 + 5 * j)});
    check_stream("bp");
    check("bp_ovf_sticky", 32'(overflow), 1);
    check("bp_level_drained", 32'(level), 0);

    // Full with simultaneous pop and write.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 80; i++) drive(1'b1, i);
    check("full_level", 32'(level), 16);
    check("full_ovf", 32'(overflow), 0);
    tready = 1'b1;
    drive(1'b1, 80);
    check("rw_level", 32'(level), 16);
    check("rw_ovf", 32'(overflow), 0);
    check("rw_head", 32'(tdata), 5);
    tready = 1'b0;

    // Clear/set collision on the full FIFO.
    for (int i = 81; i < 85; i++) drive(1'b1, i);
    check("col_ovf_pre", 32'(overflow), 0);
    drive(1'b1, 85);
    check("col_ovf_set", 32'(overflow), 1);
    for (int i = 86; i < 90; i++) drive(1'b1, i);
    clr_ovf = 1'b1;
    drive(1'b1, 90);
    check("col_set_wins", 32'(overflow), 1);
    drive(1'b0, 0);
    check("col_clear", 32'(overflow), 0);
    clr_ovf = 1'b0;
    check("col_level", 32'(level), 16);
    check("col_head", 32'(tdata), 5);

    // Asynchronous reset mid-stream.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 35; i++) drive(1'b1, i);
    check("ar_level_pre", 32'(level), 7);
    check("ar_tvalid_pre", 32'(tvalid), 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_tvalid_async", 32'(tvalid), 0);
    check("ar_level_async", 32'(level), 0);
    #2 rst = 1'b0;
    #1;
    check("ar_tvalid_rel", 32'(tvalid), 0);
    check("ar_level_rel", 32'(level), 0);
    popped.delete();
    expq.delete();
    tready = 1'b1;
    drive(1'b1, 42);
    check("ar_first_tvalid", 32'(tvalid), 1);
    check("ar_first_tdata", 32'(tdata), 42);
    check("ar_first_level", 32'(level), 1);
    for (int i = 43; i < 362; i++) drive(1'b1, i);
    for (int c = 0; c < 5; c++) drive(1'b0, 0);
    for (int j = 0; j < 64; j++) expq.push_back({(j == 63) ? 1'b1 : 1'b0, 16'(42 + 5 * j)});
    check_stream("ar");
    check("ar_ovf", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
